// File: rtl/dff_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dff_pkg
//  Description : Shared constants and width helpers for the D flip-flop
//                delay line family. Provides a constant-foldable ceil(log2)
//                plus the tap-select and occupancy-counter width rules so
//                every file derives identical widths from DEPTH.
//  Contents    : c_default_rst_val - default stage reset/flush value
//                clog2()           - ceil(log2(value)), clog2(1) = 0
//                tap_width()       - max(1, clog2(depth))
//                occ_width()       - clog2(depth + 1)
//  Revision    : 1.0 - initial release
// ============================================================================
package dff_pkg;

    // Default value loaded into every stage on reset or flush.
    localparam int c_default_rst_val = 0;

    // Ceiling log2; used at elaboration time only.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

    // Tap select needs at least one bit, even for a single stage.
    function automatic int tap_width(input int depth);
        return (clog2(depth) < 1) ? 1 : clog2(depth);
    endfunction

    // Occupancy must represent 0..depth inclusive.
    function automatic int occ_width(input int depth);
        return clog2(depth + 1);
    endfunction

endpackage : dff_pkg
`default_nettype wire

// File: rtl/dff_stage.sv
`default_nettype none
// ============================================================================
//  Module      : dff_stage
//  Description : One {valid, data} register of the delay line. Reset is
//                asynchronous; flush is synchronous; both load RST_VAL with
//                valid cleared. Priority: rst > sclr > ce > hold.
//  Ports       : clk      - clock, rising edge
//                rst      - asynchronous reset, active-high
//                ce       - clock enable (0 = hold)
//                sclr     - synchronous flush, active-high
//                d        - data in  (WIDTH)
//                d_valid  - valid tag in
//                q        - registered data out (WIDTH)
//                q_valid  - registered valid tag out
//  Revision    : 1.0 - initial release
// ============================================================================
module dff_stage
    import dff_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = WIDTH'(c_default_rst_val)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             sclr,
    input  logic [WIDTH-1:0] d,
    input  logic             d_valid,
    output logic [WIDTH-1:0] q,
    output logic             q_valid
);

    logic [WIDTH-1:0] r_data;
    logic             r_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data  <= RST_VAL;
            r_valid <= 1'b0;
        end else if (sclr) begin
            // Flush wins over enable; the incoming word is dropped.
            r_data  <= RST_VAL;
            r_valid <= 1'b0;
        end else if (ce) begin
            r_data  <= d;
            r_valid <= d_valid;
        end
    end

    assign q       = r_data;
    assign q_valid = r_valid;

endmodule : dff_stage
`default_nettype wire

// File: rtl/dff_delay_line.sv
`default_nettype none
// ============================================================================
//  Module      : dff_delay_line
//  Description : Parametrised multi-stage D flip-flop delay line. WIDTH-bit
//                data plus a valid tag are delayed by DEPTH clock-enabled
//                cycles. Includes synchronous flush, a runtime tap onto any
//                stage and a running count of valid entries in flight.
//  Ports       : clk       - clock, rising edge
//                rst       - asynchronous reset, active-high
//                ce        - clock enable; 0 = all stages and occ hold
//                sclr      - synchronous flush, active-high
//                d         - data into stage 0 (WIDTH)
//                d_valid   - valid tag travelling with d
//                tap_sel   - runtime stage select for tap_q (TAP_W)
//                q         - last stage data (stage DEPTH-1)
//                q_valid   - last stage valid tag
//                tap_q     - data of stage tap_sel
//                tap_valid - valid tag of stage tap_sel
//                occ       - number of stages holding valid=1 (OCC_W)
//  Revision    : 1.0 - initial release
// ============================================================================
module dff_delay_line
    import dff_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter int               DEPTH   = 4,
    parameter logic [WIDTH-1:0] RST_VAL = WIDTH'(c_default_rst_val),
    localparam int              TAP_W   = tap_width(DEPTH),
    localparam int              OCC_W   = occ_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             sclr,
    input  logic [WIDTH-1:0] d,
    input  logic             d_valid,
    input  logic [TAP_W-1:0] tap_sel,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    output logic [WIDTH-1:0] tap_q,
    output logic             tap_valid,
    output logic [OCC_W-1:0] occ
);

    // ------------------------------------------------------------------
    // Register chain
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] w_data [DEPTH];
    logic [DEPTH-1:0] w_valid;

    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        logic [WIDTH-1:0] w_stage_d;
        logic             w_stage_dv;

        if (g == 0) begin : g_head
            assign w_stage_d  = d;
            assign w_stage_dv = d_valid;
        end else begin : g_body
            assign w_stage_d  = w_data[g-1];
            assign w_stage_dv = w_valid[g-1];
        end

        dff_stage #(
            .WIDTH   (WIDTH),
            .RST_VAL (RST_VAL)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .ce      (ce),
            .sclr    (sclr),
            .d       (w_stage_d),
            .d_valid (w_stage_dv),
            .q       (w_data[g]),
            .q_valid (w_valid[g])
        );
    end

    assign q       = w_data[DEPTH-1];
    assign q_valid = w_valid[DEPTH-1];

    // ------------------------------------------------------------------
    // Occupancy counter
    // Tracked incrementally instead of a popcount: one valid enters at
    // stage 0 and one leaves from the last stage per enabled edge, so the
    // count moves by at most one and a simultaneous in/out leaves it alone.
    // Because it mirrors the stage valids exactly it can neither exceed
    // DEPTH nor drop below zero.
    // ------------------------------------------------------------------
    logic [OCC_W-1:0] r_occ;
    logic [OCC_W-1:0] w_occ_next;

    always_comb begin
        w_occ_next = r_occ;
        if (d_valid && !w_valid[DEPTH-1]) begin
            w_occ_next = r_occ + 1'b1;
        end else if (!d_valid && w_valid[DEPTH-1]) begin
            w_occ_next = r_occ - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_occ <= '0;
        end else if (sclr) begin
            r_occ <= '0;
        end else if (ce) begin
            r_occ <= w_occ_next;
        end
    end

    assign occ = r_occ;

    // ------------------------------------------------------------------
    // Tap mux
    // Selects beyond the last stage (possible when DEPTH is not a power
    // of two, or DEPTH=1) fall through to the reset value with valid low.
    // ------------------------------------------------------------------
    always_comb begin
        tap_q     = RST_VAL;
        tap_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (tap_sel == TAP_W'(i)) begin
                tap_q     = w_data[i];
                tap_valid = w_valid[i];
            end
        end
    end

endmodule : dff_delay_line
`default_nettype wire
